scan_index_counter: RTL and testbench

//  Parametrised coefficient-scan index counter for the CAVLC encoder.

---
 rtl/scan_index_counter.sv | 113 +++++++++++
 tb/tb_scan_index_counter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_index_counter.sv
// Coefficient-scan index counter: up/down zig-zag index per block, with stall and abort.
// Optional completed-block counter output enabled by defining SCAN_CNT_BLKCNT_EN.
module scan_index_counter #(
    parameter int MAX_COUNT = 15,
    parameter int WIDTH     = 4
`ifdef SCAN_CNT_BLKCNT_EN
    ,
    parameter int BLK_W     = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
`ifdef SCAN_CNT_BLKCNT_EN
    ,
    output logic [BLK_W-1:0] blk_cnt
`endif
);

    generate
        if (MAX_COUNT >= (1 << WIDTH) || MAX_COUNT < 0) begin : g_bad_cfg
            $error("scan_index_counter: MAX_COUNT does not fit in WIDTH");
        end
    endgenerate

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX_COUNT);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             dir_q;
    logic             dir_d;
    logic [WIDTH-1:0] count_d;
    logic             done_d;
    logic [WIDTH-1:0] terminal;
    logic             at_term;

    // Reverse scans end at index 0, forward scans at the block's top index.
    assign terminal = dir_q ? '0 : CMAX;
    assign at_term  = (count == terminal);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        count_d = count;
        done_d  = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        dir_d   = dir;
                        count_d = dir ? CMAX : '0;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (at_term) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (dir_q) begin
                            count_d = count - 1'b1;
                        end else begin
                            count_d = count + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            count   <= count_d;
            done    <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign last = busy & at_term;

`ifdef SCAN_CNT_BLKCNT_EN
    // Survives clr on purpose: only completed blocks are counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
        end else if (done_d) begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_index_counter.sv
// Bench for scan_index_counter: a 16-index and a 4-index instance against a step model.
// Directed scenarios cover up/down scans, stalls, async reset, abort and restart.
module tb_scan_index_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v = '0;
    logic [1:0] dir_v   = '0;
    logic [1:0] en_v    = '0;
    logic [1:0] clr_v   = '0;
    logic [3:0] cnt0;
    logic [1:0] cnt1;
    logic [1:0] busy_v;
    logic [1:0] last_v;
    logic [1:0] done_v;
`ifdef SCAN_CNT_BLKCNT_EN
    logic [7:0] blk0;
    logic [1:0] blk1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_index_counter #(
        .MAX_COUNT(15),
        .WIDTH(4)
`ifdef SCAN_CNT_BLKCNT_EN
        ,
        .BLK_W(8)
`endif
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .start(start_v[0]),
        .dir(dir_v[0]),
        .en(en_v[0]),
        .clr(clr_v[0]),
        .count(cnt0),
        .busy(busy_v[0]),
        .last(last_v[0]),
        .done(done_v[0])
`ifdef SCAN_CNT_BLKCNT_EN
        ,
        .blk_cnt(blk0)
`endif
    );

    scan_index_counter #(
        .MAX_COUNT(3),
        .WIDTH(2)
`ifdef SCAN_CNT_BLKCNT_EN
        ,
        .BLK_W(2)
`endif
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .start(start_v[1]),
        .dir(dir_v[1]),
        .en(en_v[1]),
        .clr(clr_v[1]),
        .count(cnt1),
        .busy(busy_v[1]),
        .last(last_v[1]),
        .done(done_v[1])
`ifdef SCAN_CNT_BLKCNT_EN
        ,
        .blk_cnt(blk1)
`endif
    );

    function automatic int mx(int i);
        return (i == 0) ? 15 : 3;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a scan is "k steps taken"; the index is derived from k and direction.
    bit m_run[2];
    bit m_dir[2];
    bit m_done[2];
    int m_k[2];
    int m_idle[2];
    int m_blk[2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_run[i]  <= 1'b0;
                m_dir[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_k[i]    <= 0;
                m_idle[i] <= 0;
                m_blk[i]  <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (clr_v[i]) begin
                    m_run[i]  <= 1'b0;
                    m_idle[i] <= 0;
                end else if (!m_run[i]) begin
                    if (start_v[i]) begin
                        m_run[i] <= 1'b1;
                        m_k[i]   <= 0;
                        m_dir[i] <= dir_v[i];
                    end
                end else if (en_v[i]) begin
                    if (m_k[i] == mx(i)) begin
                        m_run[i]  <= 1'b0;
                        m_idle[i] <= m_dir[i] ? 0 : mx(i);
                        m_done[i] <= 1'b1;
                        m_blk[i]  <= m_blk[i] + 1;
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ec;
            int ac;
            ec = m_run[i] ? (m_dir[i] ? mx(i) - m_k[i] : m_k[i]) : m_idle[i];
            ac = (i == 0) ? int'(cnt0) : int'(cnt1);
            chk($sformatf("cmp%0d count", i), ac, ec);
            chk($sformatf("cmp%0d busy", i), busy_v[i], m_run[i]);
            chk($sformatf("cmp%0d last", i), last_v[i],
                m_run[i] && (m_k[i] == mx(i)));
            chk($sformatf("cmp%0d done", i), done_v[i], m_done[i]);
`ifdef SCAN_CNT_BLKCNT_EN
            if (i == 0) chk("cmp0 blk", blk0, m_blk[0] % 256);
            else        chk("cmp1 blk", blk1, m_blk[1] % 4);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        bit any_done;
        int nd;

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) step();
        chk("reset count", cnt0, 0);
        chk("reset busy", busy_v[0], 0);
        chk("reset done", done_v[0], 0);
        rst = 1'b1;
        step();

        // Up scan, en always on
        start_v[0] = 1; dir_v[0] = 0; en_v[0] = 1;
        step();
        start_v[0] = 0;
        chk("up first count", cnt0, 0);
        chk("up first busy", busy_v[0], 1);
        chk("up first last", last_v[0], 0);
        repeat (15) step();
        chk("up end count", cnt0, 15);
        chk("up end last", last_v[0], 1);
        chk("up end done", done_v[0], 0);
        step();
        chk("up done pulse", done_v[0], 1);
        chk("up done busy", busy_v[0], 0);
        chk("up done count", cnt0, 15);
        step();
        chk("up done width", done_v[0], 0);

        // Down scan with alternating stalls
        start_v[0] = 1; dir_v[0] = 1; en_v[0] = 0;
        step();
        start_v[0] = 0;
        chk("down first count", cnt0, 15);
        n = 0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            en_v[0] = (c % 2 == 0);
            if (busy_v[0] && en_v[0]) n++;
            step();
            if (done_v[0]) seen = 1;
        end
        en_v[0] = 0;
        chk("down done seen", seen, 1);
        chk("down enabled cycles", n, 16);
        chk("down end count", cnt0, 0);

        // Async reset mid-scan
        start_v[0] = 1; dir_v[0] = 0; en_v[0] = 1;
        step();
        start_v[0] = 0;
        repeat (7) step();
        chk("rst pre count", cnt0, 7);
        #2 rst = 1'b0;
        #1;
        chk("rst async count", cnt0, 0);
        chk("rst async busy", busy_v[0], 0);
        @(posedge clk);
        #3 rst = 1'b1;
        any_done = 0;
        repeat (20) begin
            step();
            if (done_v[0] || busy_v[0]) any_done = 1;
        end
        chk("rst no done", any_done, 0);

        // Abort and priority
        start_v[0] = 1; dir_v[0] = 0; en_v[0] = 1;
        step();
        start_v[0] = 0;
        repeat (5) step();
        chk("clr pre count", cnt0, 5);
        clr_v[0] = 1;
        step();
        clr_v[0] = 0;
        chk("clr count", cnt0, 0);
        chk("clr busy", busy_v[0], 0);
        any_done = 0;
        repeat (3) begin
            step();
            if (done_v[0]) any_done = 1;
        end
        chk("clr no done", any_done, 0);
        clr_v[0] = 1; start_v[0] = 1;
        step();
        chk("clr beats start", busy_v[0], 0);
        clr_v[0] = 0;
        step();
        chk("start busy", busy_v[0], 1);
        chk("start count", cnt0, 0);
        dir_v[0] = 1;
        step();
        chk("start ignored 1", cnt0, 1);
        step();
        chk("start ignored 2", cnt0, 2);
        start_v[0] = 0; dir_v[0] = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (done_v[0]) seen = 1;
        end
        chk("abort test finish", seen, 1);
        en_v[0] = 0;

        // Short block, back-to-back restart
        start_v[1] = 1; dir_v[1] = 0; en_v[1] = 1;
        step();
        start_v[1] = 0;
        chk("short first count", cnt1, 0);
        repeat (3) step();
        chk("short end count", cnt1, 3);
        chk("short end last", last_v[1], 1);
        step();
        chk("short done", done_v[1], 1);
        start_v[1] = 1;
        step();
        start_v[1] = 0;
        chk("restart busy", busy_v[1], 1);
        chk("restart count", cnt1, 0);
        chk("restart done low", done_v[1], 0);
        repeat (4) step();
        chk("restart done", done_v[1], 1);

`ifdef SCAN_CNT_BLKCNT_EN
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        chk("blk reset", blk1, 0);
        start_v[1] = 1; en_v[1] = 1;
        nd = 0;
        for (int c = 0; c < 100 && nd < 5; c++) begin
            step();
            if (done_v[1]) nd++;
        end
        start_v[1] = 0;
        chk("blk scans", nd, 5);
        chk("blk wrap", blk1, 1);
        start_v[1] = 1;
        step();
        start_v[1] = 0;
        step();
        step();
        clr_v[1] = 1;
        step();
        clr_v[1] = 0;
        step();
        chk("blk abort", blk1, 1);
        chk("blk abort busy", busy_v[1], 0);
`else
        nd = 0;
`endif
        en_v = '0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
